// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency byte/half/word data memory behind valid/ready request and response channels
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);
  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic we_q, uns_q;
  logic [1:0] size_q;
  logic [31:0] addr_q, wdata_q;
  logic idle, accept, commit;
  logic e_we, e_uns, e_err;
  logic [1:0] e_size;
  logic [31:0] e_addr, e_wdata;
  logic [AW-1:0] idx;
  logic [3:0] be;
  logic [31:0] wlane, rword, shifted, ldata;
  logic [3:0][7:0] mem [DEPTH_WORDS];
  assign idle = state == IDLE;
  assign accept = idle && req_valid_i;
  assign req_ready_o = idle;
  assign resp_valid_o = state == RESP;
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    case (state)
      IDLE: if (req_valid_i) begin
        state_nx = LATENCY == 1 ? RESP : WAIT;
        cnt_nx = CNT_LOAD;
      end
      WAIT: begin
        cnt_nx = cnt - 4'd1;
        state_nx = cnt == 4'd1 ? RESP : WAIT;
      end
      RESP: state_nx = resp_ready_i ? IDLE : RESP;
      default: state_nx = IDLE;
    endcase
  end
  // With LATENCY==1 the commit edge is the acceptance edge, so the live inputs are used
  assign commit = rst_n && state != RESP && state_nx == RESP;
  assign e_we = idle ? req_we_i : we_q;
  assign e_uns = idle ? req_unsigned_i : uns_q;
  assign e_size = idle ? req_size_i : size_q;
  assign e_addr = idle ? req_addr_i : addr_q;
  assign e_wdata = idle ? req_wdata_i : wdata_q;
  assign e_err = e_size == 2'b11 || (e_size == 2'b01 && e_addr[0]) ||
                 (e_size == 2'b10 && e_addr[1:0] != 2'b00) ||
                 {2'b00, e_addr[31:2]} >= 32'(DEPTH_WORDS);
  assign idx = e_addr[AW+1:2];
  assign be = e_size == 2'b00 ? 4'b0001 << e_addr[1:0] :
              e_size == 2'b01 ? (e_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wlane = e_size == 2'b00 ? {4{e_wdata[7:0]}} :
                 e_size == 2'b01 ? {2{e_wdata[15:0]}} : e_wdata;
  assign rword = mem[idx];
  assign shifted = rword >> {e_addr[1:0], 3'b000};
  assign ldata = e_size == 2'b00 ? {{24{~e_uns & shifted[7]}}, shifted[7:0]} :
                 e_size == 2'b01 ? {{16{~e_uns & shifted[15]}}, shifted[15:0]} : rword;
  always_ff @(posedge clk) begin
    if (commit && e_we && !e_err)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][i] <= wlane[8*i +: 8];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      we_q <= 1'b0;
      uns_q <= 1'b0;
      size_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      resp_rdata_o <= '0;
      resp_err_o <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      if (accept) begin
        we_q <= req_we_i;
        uns_q <= req_unsigned_i;
        size_q <= req_size_i;
        addr_q <= req_addr_i;
        wdata_q <= req_wdata_i;
      end
      if (commit) begin
        resp_rdata_o <= e_we || e_err ? 32'd0 : ldata;
        resp_err_o <= e_err;
      end
    end
  end
endmodule
